// File: rtl/dfp_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache (0) and D-cache (1).
// After a completed write the port stays reserved briefly so the owner's allocate read follows atomically.
module dfp_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LINE_W-1:0] req0_wdata,
    output logic [LINE_W-1:0] req0_rdata,
    output logic              req0_resp,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LINE_W-1:0] req1_wdata,
    output logic [LINE_W-1:0] req1_rdata,
    output logic              req1_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              op_wr_q, op_wr_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic act0, act1;
    logic load;
    logic pick;
    logic busy;

    assign act0 = req0_read | req0_write;
    assign act1 = req1_read | req1_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            op_wr_q    <= 1'b0;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            op_wr_q    <= op_wr_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Payload is only driven out while BUSY, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            addr_q  <= pick ? req1_addr  : req0_addr;
            wdata_q <= pick ? req1_wdata : req0_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        op_wr_d    = op_wr_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        load       = 1'b0;
        pick       = owner_q;
        case (state_q)
            IDLE: begin
                if (act0 | act1) begin
                    pick    = (act0 & act1) ? ~last_q : act1;
                    load    = 1'b1;
                    last_d  = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    if (op_wr_q) begin
                        state_d    = HOLD;
                        hold_cnt_d = CNT_W'(HOLD_CYC);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                // Owner's follow-up bypasses arbitration and does not count as a new grant.
                if (owner_q ? act1 : act0) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                    if (hold_cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            owner_d = pick;
            op_wr_d = pick ? req1_write : req0_write;
        end
    end

    always_comb begin
        busy      = (state_q == BUSY);
        mem_read  = busy & ~op_wr_q;
        mem_write = busy & op_wr_q;
        mem_addr  = busy ? addr_q : '0;
        mem_wdata = busy ? wdata_q : '0;
        req0_resp = busy & mem_resp & ~owner_q;
        req1_resp = busy & mem_resp & owner_q;
    end

    assign req0_rdata = mem_rdata;
    assign req1_rdata = mem_rdata;

endmodule

// File: tb/tb_dfp_arbiter.sv
// Directed scenarios plus a randomized run of two cache-like requesters against a cycle/transaction model.
module tb_dfp_arbiter;
    localparam int ADDR_W    = 32;
    localparam int LINE_W    = 256;
    localparam int HOLD_CYC  = 2;
    localparam int NCYC      = 2500;
    localparam int EV_NONE   = 0;
    localparam int EV_DROP   = 1;
    localparam int EV_RAISE0 = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_read, req0_write, req1_read, req1_write;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [LINE_W-1:0] req0_wdata, req1_wdata;
    logic [LINE_W-1:0] req0_rdata, req1_rdata;
    logic              req0_resp, req1_resp;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int checks   = 0;
    int failures = 0;

    // Randomized-phase model state
    logic [LINE_W-1:0] mem_q [logic [ADDR_W-1:0]];
    logic              a_act [2];
    logic              a_wr [2];
    logic              a_alloc [2];
    logic [ADDR_W-1:0] a_addr [2];
    logic [ADDR_W-1:0] a_alloc_addr [2];
    logic [LINE_W-1:0] a_data [2];
    int                a_gap [2];
    int                a_wait [2];
    int                a_max_wait [2];
    int                a_nresp [2];
    logic              got [2];
    logic              m_busy;
    logic              resp_now;
    logic              t_wr;
    logic [ADDR_W-1:0] t_addr;
    logic [LINE_W-1:0] t_data;
    int                t_owner, m_pend, m_wait, m_last, hold_owner, hold_until;

    always #5 clk = ~clk;

    dfp_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .rst(rst),
        .req0_read(req0_read), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
        .req1_read(req1_read), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0_read = 1'b0; req0_write = 1'b0; req1_read = 1'b0; req1_write = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr(input int who);
        return ADDR_W'(32'h0001_0000 * who + ($urandom_range(0, 15) << 5));
    endfunction

    function automatic logic [LINE_W-1:0] mem_lookup(input logic [ADDR_W-1:0] a);
        if (mem_q.exists(a)) return mem_q[a];
        return {(LINE_W/32){a ^ 32'hA5A5_0000}};
    endfunction

    // One memory transaction seen from the bench: starts the cycle after the caller's setup, resp on cycle lat.
    task automatic expect_txn(input string tag, input logic [ADDR_W-1:0] addr, input logic wr,
                              input logic owner, input logic [LINE_W-1:0] wdata, input int lat, input int ev);
        logic [LINE_W-1:0] pat;
        pat = {(LINE_W/32){addr ^ 32'h5A5A_0000}};
        for (int i = 0; i < lat; i++) begin
            tick();
            if (ev == EV_DROP && i == 1) begin
                if (owner) begin req1_read = 1'b0; req1_write = 1'b0; end
                else begin req0_read = 1'b0; req0_write = 1'b0; end
            end
            if (ev == EV_RAISE0 && i == 0) req0_read = 1'b1;
            mem_resp  = (i == lat - 1);
            mem_rdata = (i == lat - 1) ? pat : ~pat;
            #1;
            chk({tag, ".mem_read"}, mem_read, !wr);
            chk({tag, ".mem_write"}, mem_write, wr);
            chk({tag, ".mem_addr"}, mem_addr, addr);
            if (wr) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
            chk({tag, ".resp0"}, req0_resp, (i == lat - 1) && !owner);
            chk({tag, ".resp1"}, req1_resp, (i == lat - 1) && owner);
            if (i == lat - 1 && !wr) chk({tag, ".rdata"}, owner ? req1_rdata : req0_rdata, pat);
        end
    endtask

    task automatic agent_issue(input int i);
        a_act[i] = 1'b1;
        if (a_alloc[i]) begin
            a_wr[i]    = 1'b0;
            a_addr[i]  = a_alloc_addr[i];
            a_alloc[i] = 1'b0;
        end else begin
            a_wr[i]   = ($urandom_range(0, 2) == 0);
            a_addr[i] = rand_addr(i);
        end
        a_data[i] = rand_line();
    endtask

    task automatic agent_update(input int i);
        if (a_act[i] && got[i]) begin
            a_act[i]        = 1'b0;
            a_nresp[i]++;
            a_wait[i]       = 0;
            a_alloc[i]      = a_wr[i] && ($urandom_range(0, 1) == 1);
            a_alloc_addr[i] = rand_addr(i);
            a_gap[i]        = a_alloc[i] ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
        end else if (a_act[i]) begin
            a_wait[i]++;
            if (a_wait[i] > a_max_wait[i]) a_max_wait[i] = a_wait[i];
        end
        if (!a_act[i]) begin
            if (a_gap[i] == 0) agent_issue(i);
            else a_gap[i]--;
        end
    endtask

    task automatic drive_agents();
        req0_read  = a_act[0] & ~a_wr[0];
        req0_write = a_act[0] & a_wr[0];
        req0_addr  = a_addr[0];
        req0_wdata = a_data[0];
        req1_read  = a_act[1] & ~a_wr[1];
        req1_write = a_act[1] & a_wr[1];
        req1_addr  = a_addr[1];
        req1_wdata = a_data[1];
    endtask

    initial begin
        rst = 1'b0;
        req0_read = 1'b0; req0_write = 1'b0; req1_read = 1'b0; req1_write = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        #12;
        chk("rst.mem_read", mem_read, 1'b0);
        chk("rst.mem_write", mem_write, 1'b0);
        chk("rst.mem_addr", mem_addr, '0);
        chk("rst.mem_wdata", mem_wdata, '0);
        mem_resp = 1'b1;
        #1;
        chk("rst.resp0", req0_resp, 1'b0);
        chk("rst.resp1", req1_resp, 1'b0);
        mem_resp = 1'b0;
        tick();
        rst = 1'b1;

        // Single read, memory answers on the third BUSY cycle
        req0_read = 1'b1; req0_addr = 32'h1000; #1;
        chk("t1.idle_rd", mem_read, 1'b0);
        expect_txn("t1.rd", 32'h1000, 1'b0, 1'b0, '0, 3, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; #1;
        chk("t1.after_rd", mem_read, 1'b0);
        chk("t1.after_resp", req0_resp, 1'b0);

        // Tie out of reset, then alternation
        do_reset();
        req0_read = 1'b1; req0_addr = 32'hA000; req1_read = 1'b1; req1_addr = 32'hB000; #1;
        expect_txn("t2.first", 32'hA000, 1'b0, 1'b0, '0, 1, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; #1;
        chk("t2.gap", mem_read, 1'b0);
        expect_txn("t2.second", 32'hB000, 1'b0, 1'b1, '0, 1, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b1; #1;
        chk("t2.gap2", mem_read, 1'b0);
        expect_txn("t2.again0", 32'hA000, 1'b0, 1'b0, '0, 2, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; #1;
        expect_txn("t2.again1", 32'hB000, 1'b0, 1'b1, '0, 1, EV_NONE);
        tick(); mem_resp = 1'b0; req1_read = 1'b0; #1;

        // Write-back then allocate from req1 while req0 waits
        req1_write = 1'b1; req1_addr = 32'h2000; req1_wdata = {8{32'hDEAD_0001}}; req0_addr = 32'h4000; #1;
        expect_txn("t3.wb", 32'h2000, 1'b1, 1'b1, {8{32'hDEAD_0001}}, 2, EV_RAISE0);
        tick(); mem_resp = 1'b0; req1_write = 1'b0; req1_read = 1'b1; req1_addr = 32'h3000; #1;
        chk("t3.hold_rd", mem_read, 1'b0);
        chk("t3.hold_wr", mem_write, 1'b0);
        expect_txn("t3.alloc", 32'h3000, 1'b0, 1'b1, '0, 2, EV_NONE);
        tick(); mem_resp = 1'b0; req1_read = 1'b0; #1;
        chk("t3.idle", mem_read, 1'b0);
        expect_txn("t3.r0", 32'h4000, 1'b0, 1'b0, '0, 1, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; #1;

        // Hold window expires with the owner idle; spurious resp inside the window
        req1_write = 1'b1; req1_addr = 32'h5000; req1_wdata = {8{32'hBEEF_0002}}; req0_addr = 32'h6000; #1;
        expect_txn("t4.wb", 32'h5000, 1'b1, 1'b1, {8{32'hBEEF_0002}}, 2, EV_RAISE0);
        tick(); mem_resp = 1'b1; req1_write = 1'b0; #1;
        chk("t4.h1_rd", mem_read, 1'b0);
        chk("t4.h1_resp0", req0_resp, 1'b0);
        chk("t4.h1_resp1", req1_resp, 1'b0);
        tick(); mem_resp = 1'b0; #1;
        chk("t4.h2_rd", mem_read, 1'b0);
        tick(); #1;
        chk("t4.idle_rd", mem_read, 1'b0);
        expect_txn("t4.r0", 32'h6000, 1'b0, 1'b0, '0, 1, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; #1;

        // Reset in the middle of a read
        req0_read = 1'b1; req0_addr = 32'h7000; #1;
        tick(); #1;
        chk("t5.busy_rd", mem_read, 1'b1);
        #2; rst = 1'b0; #1;
        chk("t5.rst_rd", mem_read, 1'b0);
        chk("t5.rst_addr", mem_addr, '0);
        mem_resp = 1'b1; #1;
        chk("t5.rst_resp0", req0_resp, 1'b0);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; rst = 1'b1;
        req1_read = 1'b1; req1_addr = 32'h8000; #1;
        chk("t5.idle_rd", mem_read, 1'b0);
        expect_txn("t5.r1_drop", 32'h8000, 1'b0, 1'b1, '0, 3, EV_DROP);
        tick(); mem_resp = 1'b0; #1;
        chk("t5.after_rd", mem_read, 1'b0);

        // Spurious resp in IDLE, then a tie still follows round-robin order
        tick(); mem_resp = 1'b1; #1;
        chk("t6.resp0", req0_resp, 1'b0);
        chk("t6.resp1", req1_resp, 1'b0);
        chk("t6.rd", mem_read, 1'b0);
        tick(); mem_resp = 1'b0;
        req0_read = 1'b1; req0_addr = 32'h9000; req1_read = 1'b1; req1_addr = 32'hA000; #1;
        expect_txn("t6.tie0", 32'h9000, 1'b0, 1'b0, '0, 1, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; #1;
        expect_txn("t6.tie1", 32'hA000, 1'b0, 1'b1, '0, 1, EV_NONE);
        tick(); mem_resp = 1'b0; req1_read = 1'b0; #1;

        // Read and write together: write wins
        req0_read = 1'b1; req0_write = 1'b1; req0_addr = 32'hC000; req0_wdata = {8{32'h1234_5678}}; #1;
        expect_txn("t7.rw", 32'hC000, 1'b1, 1'b0, {8{32'h1234_5678}}, 2, EV_NONE);
        tick(); mem_resp = 1'b0; req0_read = 1'b0; req0_write = 1'b0; #1;
        chk("t7.hold_wr", mem_write, 1'b0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2; i++) begin
            a_act[i] = 1'b0; a_wr[i] = 1'b0; a_alloc[i] = 1'b0;
            a_addr[i] = '0; a_alloc_addr[i] = '0; a_data[i] = '0;
            a_gap[i] = int'($urandom_range(0, 3));
            a_wait[i] = 0; a_max_wait[i] = 0; a_nresp[i] = 0;
        end
        m_busy = 1'b0; m_pend = -1; m_wait = 0; m_last = 1;
        hold_owner = 0; hold_until = -1; t_owner = 0;
        t_wr = 1'b0; t_addr = '0; t_data = '0;
        for (int c = 0; c < NCYC; c++) begin
            tick();
            drive_agents();
            resp_now = 1'b0;
            if (m_busy) begin
                if (m_wait == 0) resp_now = 1'b1;
                else m_wait--;
            end
            mem_resp  = resp_now | (!m_busy && m_pend < 0 && $urandom_range(0, 7) == 0);
            mem_rdata = (resp_now && !t_wr) ? mem_lookup(t_addr) : rand_line();
            #1;
            got[0] = 1'b0;
            got[1] = 1'b0;
            if (m_pend >= 0) begin
                t_owner = m_pend;
                m_pend  = -1;
                m_busy  = 1'b1;
                m_wait  = int'($urandom_range(0, 3));
                chk("rnd.start_rd", mem_read, !t_wr);
                chk("rnd.start_wr", mem_write, t_wr);
                chk("rnd.start_addr", mem_addr, t_addr);
                if (t_wr) chk("rnd.start_wdata", mem_wdata, t_data);
                chk("rnd.start_resp", {req1_resp, req0_resp}, 2'b00);
            end else if (m_busy) begin
                chk("rnd.busy_rd", mem_read, !t_wr);
                chk("rnd.busy_wr", mem_write, t_wr);
                chk("rnd.busy_addr", mem_addr, t_addr);
                chk("rnd.resp0", req0_resp, resp_now && t_owner == 0);
                chk("rnd.resp1", req1_resp, resp_now && t_owner == 1);
                if (resp_now) begin
                    if (t_wr) mem_q[t_addr] = t_data;
                    else chk("rnd.rdata", (t_owner == 1) ? req1_rdata : req0_rdata, mem_lookup(t_addr));
                    got[t_owner] = 1'b1;
                    m_busy       = 1'b0;
                    hold_owner   = t_owner;
                    hold_until   = t_wr ? c + HOLD_CYC : c;
                end
            end else begin
                chk("rnd.free_port", {mem_write, mem_read}, 2'b00);
                chk("rnd.free_resp", {req1_resp, req0_resp}, 2'b00);
                if (c <= hold_until) begin
                    if (a_act[hold_owner]) m_pend = hold_owner;
                end else if (a_act[0] || a_act[1]) begin
                    m_pend = (a_act[0] && a_act[1]) ? 1 - m_last : (a_act[1] ? 1 : 0);
                    m_last = m_pend;
                end
                if (m_pend >= 0) begin
                    t_wr   = a_wr[m_pend];
                    t_addr = a_addr[m_pend];
                    t_data = a_data[m_pend];
                end
            end
            agent_update(0);
            agent_update(1);
        end
        chk("rnd.served0", a_nresp[0] > 20, 1'b1);
        chk("rnd.served1", a_nresp[1] > 20, 1'b1);
        chk("rnd.wait0_bound", a_max_wait[0] < 40, 1'b1);
        chk("rnd.wait1_bound", a_max_wait[1] < 40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dfp_arbiter.md
Name: dfp_arbiter

Overview:
- Shares one line-wide memory port between two cache controllers: requester 0 is the I-cache and requester 1 is the D-cache.
- Each requester uses the cache's downstream handshake: read or write level held until a one-cycle resp.
- Arbitration is round-robin between requesters.
- A write-back followed by allocate from the same cache is kept atomic by a short post-write hold window.
- Sits between the cache FSMs and the memory/adaptor interface.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits
HOLD_CYC, 2, cycles the grant is reserved for the owner after a completed write (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
req0_read  in  1  requester 0 read request (level)
req0_write  in  1  requester 0 write request (level)
req0_addr  in  ADDR_W  requester 0 line address
req0_wdata  in  LINE_W  requester 0 write line
req0_rdata  out  LINE_W  read line to requester 0
req0_resp  out  1  completion pulse to requester 0
req1_read, req1_write, req1_addr, req1_wdata, req1_rdata, req1_resp  (same as requester 0)
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_addr  out  ADDR_W  memory address
mem_wdata  out  LINE_W  memory write line
mem_rdata  in  LINE_W  memory read line
mem_resp  in  1  memory completion pulse

Behaviour:
- State registers: state {IDLE, BUSY, HOLD}, owner (1b), op_is_write (1b), addr_q, wdata_q, last_grant (1b), hold_cnt (clog2(HOLD_CYC+1) bits).
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=0, last_grant=1 (req0 wins the first tie), hold_cnt=0.
  - All outputs 0: mem_read, mem_write, req*_resp, mem_addr, mem_wdata.
- A requester is active when read|write. If both are asserted, write takes precedence (protocol violation, still defined).
- IDLE:
  - No active requester: stay in IDLE.
  - One active requester: grant it.
  - Both active: grant !last_grant.
  - On grant: latch owner, op_is_write, addr_q, wdata_q; set last_grant=owner; go BUSY.
  - mem_read and mem_write are 0 in IDLE. Arbitration latency is one cycle.
- BUSY:
  - mem_read = !op_is_write; mem_write = op_is_write; mem_addr = addr_q; mem_wdata = wdata_q.
  - These are combinational from the registers and held stable until mem_resp.
  - On mem_resp:
    - reqN_resp = 1 for owner only, in the same cycle.
    - If op_is_write: go HOLD with hold_cnt=HOLD_CYC.
    - Otherwise: go IDLE.
- HOLD:
  - mem_read and mem_write are 0. The other requester is not granted.
  - Owner active: latch its request, go BUSY directly (no re-arbitration; last_grant unchanged).
  - Otherwise decrement hold_cnt; at 1 -> IDLE.
- rdata: req0_rdata and req1_rdata both equal mem_rdata (broadcast). Only the owner's resp qualifies it.
- Boundary cases:
  - mem_resp in IDLE or HOLD: ignored; no resp is generated.
  - A request arriving on the same cycle as mem_resp: not seen until the next IDLE or HOLD cycle.
  - Requester dropping its request mid-BUSY: the operation still completes using latched values; the resp pulse is still delivered.
  - Reset mid-operation: immediate return to IDLE with all outputs 0. The outstanding memory transaction is abandoned.
- Fairness:
  - With both requesters continuously active, grants alternate.
  - A write+allocate pair counts as one grant.
  - Worst-case wait is one transaction pair.

Test Plan:
- Single read: req0_read=1, addr=0x1000 -> mem_read=1 with mem_addr=0x1000 the next cycle. Memory resp after 3 cycles -> req0_resp pulses 1 cycle with rdata; mem_read=0 the following cycle.
- Tie:
  - Stimulus: req0_read and req1_read both asserted out of reset.
  - Required: req0 is served first, then req1.
  - Then: re-assert both -> req0 is served again (alternation holds).
- Write-back atomicity:
  - Stimulus: req1_write to 0x2000, then req1_read to 0x3000 one cycle after resp; req0_read is held throughout.
  - Required: the mem sequence is write 0x2000, read 0x3000, then req0's read.
- Hold expiry: HOLD_CYC=2; req1 write completes and req1 stays idle -> state returns to IDLE after 2 cycles; pending req0 is granted on the next cycle.
- Reset during BUSY: assert rst=0 mid-read -> mem_read drops immediately; no resp. After release, a new req1 request is granted normally.
- Spurious mem_resp in IDLE -> no req*_resp asserted; state unchanged.
